// File: rtl/mem_bus_stage.sv
// MEM pipeline stage: passes non-memory ops straight through and runs a
// req/ack data-bus transaction for loads and stores, stalling the pipeline
// until the transfer completes, aborts on timeout, or is rejected as misaligned.
module mem_bus_stage #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic [4:0]  mem_wd_i,
  input  logic        mem_wreg_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [7:0]  mem_aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_reg2_i,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_sel_o,
  output logic [31:0] dbus_wdata_o,
  input  logic [31:0] dbus_rdata_i,
  input  logic        dbus_ack_i,
  output logic [4:0]  wb_wd_o,
  output logic        wb_wreg_o,
  output logic [31:0] wb_wdata_o,
  output logic        stallreq_o,
  output logic        misalign_o,
  output logic        timeout_o
);

  localparam logic [7:0] OP_LB  = 8'hE0;
  localparam logic [7:0] OP_LBU = 8'hE4;
  localparam logic [7:0] OP_LH  = 8'hE1;
  localparam logic [7:0] OP_LHU = 8'hE5;
  localparam logic [7:0] OP_LW  = 8'hE3;
  localparam logic [7:0] OP_SB  = 8'hE8;
  localparam logic [7:0] OP_SH  = 8'hE9;
  localparam logic [7:0] OP_SW  = 8'hEB;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      data_q;
  logic             to_q;
  logic             ld_q;

  logic        is_load;
  logic        is_store;
  logic        sz_half;
  logic        sz_word;
  logic        ld_signed;
  logic        mem_op;
  logic        misal;
  logic [3:0]  sel_n;
  logic [31:0] wdata_n;
  logic [31:0] ld_fmt;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Classify the opcode into load/store and access size.
  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    sz_half   = 1'b0;
    sz_word   = 1'b0;
    ld_signed = 1'b0;
    case (mem_aluop_i)
      OP_LB:  begin is_load = 1'b1; ld_signed = 1'b1; end
      OP_LBU: is_load = 1'b1;
      OP_LH:  begin is_load = 1'b1; sz_half = 1'b1; ld_signed = 1'b1; end
      OP_LHU: begin is_load = 1'b1; sz_half = 1'b1; end
      OP_LW:  begin is_load = 1'b1; sz_word = 1'b1; end
      OP_SB:  is_store = 1'b1;
      OP_SH:  begin is_store = 1'b1; sz_half = 1'b1; end
      OP_SW:  begin is_store = 1'b1; sz_word = 1'b1; end
      default: ;
    endcase
  end

  assign mem_op = mem_valid_i & (is_load | is_store);
  assign misal  = (sz_half & mem_addr_i[0]) | (sz_word & (mem_addr_i[1:0] != 2'b00));

  // Store byte-lane enables and replicated write data (big-endian lanes).
  always_comb begin
    sel_n   = 4'b1111;
    wdata_n = '0;
    if (is_store) begin
      if (sz_word) begin
        wdata_n = mem_reg2_i;
      end else if (sz_half) begin
        sel_n   = mem_addr_i[1] ? 4'b0011 : 4'b1100;
        wdata_n = {2{mem_reg2_i[15:0]}};
      end else begin
        sel_n   = 4'b1000 >> mem_addr_i[1:0];
        wdata_n = {4{mem_reg2_i[7:0]}};
      end
    end
  end

  // Extract and extend load data; opcode/address are held stable while stalled.
  always_comb begin
    case (mem_addr_i[1:0])
      2'd0:    byte_v = dbus_rdata_i[31:24];
      2'd1:    byte_v = dbus_rdata_i[23:16];
      2'd2:    byte_v = dbus_rdata_i[15:8];
      default: byte_v = dbus_rdata_i[7:0];
    endcase
    half_v = mem_addr_i[1] ? dbus_rdata_i[15:0] : dbus_rdata_i[31:16];
    if (sz_word) begin
      ld_fmt = dbus_rdata_i;
    end else if (sz_half) begin
      ld_fmt = {{16{ld_signed & half_v[15]}}, half_v};
    end else begin
      ld_fmt = {{24{ld_signed & byte_v[7]}}, byte_v};
    end
  end

  // Bus transaction sequencer with registered bus outputs and timeout counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      data_q       <= '0;
      to_q         <= 1'b0;
      ld_q         <= 1'b0;
      dbus_req_o   <= 1'b0;
      dbus_we_o    <= 1'b0;
      dbus_addr_o  <= '0;
      dbus_sel_o   <= '0;
      dbus_wdata_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op && !misal) begin
            dbus_req_o   <= 1'b1;
            dbus_we_o    <= is_store;
            dbus_addr_o  <= {mem_addr_i[31:2], 2'b00};
            dbus_sel_o   <= sel_n;
            dbus_wdata_o <= wdata_n;
            ld_q         <= is_load;
            cnt          <= '0;
            state        <= BUSY;
          end
        end
        BUSY: begin
          if (dbus_ack_i) begin
            data_q     <= ld_q ? ld_fmt : '0;
            dbus_req_o <= 1'b0;
            state      <= DONE;
          end else if (cnt == TO_LAST) begin
            data_q     <= '0;
            dbus_req_o <= 1'b0;
            to_q       <= 1'b1;
            state      <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          cnt   <= '0;
          to_q  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Writeback, stall and status outputs; all forced low while in reset.
  always_comb begin
    wb_wd_o    = '0;
    wb_wreg_o  = 1'b0;
    wb_wdata_o = '0;
    stallreq_o = 1'b0;
    misalign_o = 1'b0;
    timeout_o  = 1'b0;
    if (rst) begin
      case (state)
        IDLE: begin
          if (!mem_op) begin
            wb_wd_o    = mem_wd_i;
            wb_wreg_o  = mem_wreg_i;
            wb_wdata_o = mem_wdata_i;
          end else if (misal) begin
            wb_wd_o    = mem_wd_i;
            misalign_o = 1'b1;
          end else begin
            stallreq_o = 1'b1;
          end
        end
        BUSY: begin
          wb_wd_o    = mem_wd_i;
          stallreq_o = 1'b1;
        end
        DONE: begin
          wb_wd_o    = mem_wd_i;
          wb_wreg_o  = ld_q & ~to_q;
          wb_wdata_o = data_q;
          timeout_o  = to_q;
        end
        default: ;
      endcase
    end
  end

endmodule
